// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if: core-store, memory-drain and status signals of the posted-store buffer.
//   master: drives MemWrite/DataAdr/WriteData/mem_ready (core + memory side), observes the rest
//   slave : the buffer itself
//   Forwarding signals LoadAdr/fwd_hit/fwd_data exist only when DMEM_WB_FORWARD_EN is defined.
interface dmem_write_buffer_if #(parameter int DEPTH = 4, parameter int AW = 32, parameter int DW = 32);
  logic                    MemWrite;
  logic [AW-1:0]           DataAdr;
  logic [DW-1:0]           WriteData;
  logic                    Stall;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  logic                    align_err;
`ifdef DMEM_WB_FORWARD_EN
  logic [AW-1:0]           LoadAdr;
  logic                    fwd_hit;
  logic [DW-1:0]           fwd_data;
  modport master (output MemWrite, DataAdr, WriteData, mem_ready, LoadAdr,
                  input Stall, mem_valid, mem_addr, mem_wdata, count, empty, align_err, fwd_hit, fwd_data);
  modport slave  (input MemWrite, DataAdr, WriteData, mem_ready, LoadAdr,
                  output Stall, mem_valid, mem_addr, mem_wdata, count, empty, align_err, fwd_hit, fwd_data);
`else
  modport master (output MemWrite, DataAdr, WriteData, mem_ready,
                  input Stall, mem_valid, mem_addr, mem_wdata, count, empty, align_err);
  modport slave  (input MemWrite, DataAdr, WriteData, mem_ready,
                  output Stall, mem_valid, mem_addr, mem_wdata, count, empty, align_err);
`endif
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store FIFO between the core store port and a valid/ready data memory.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dmem_write_buffer_if.slave (store in, drain out, count/empty/align_err status)
//   Optional store-to-load forwarding enabled by defining DMEM_WB_FORWARD_EN.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic               clk,
  input logic               reset,
  dmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          err, aligned, full, enq, deq;
  assign aligned       = bus.DataAdr[1:0] == 2'b00;
  assign full          = cnt == (PW+1)'(DEPTH);
  assign deq           = bus.mem_valid & bus.mem_ready;
  // a full buffer still accepts a store when the head leaves in the same cycle
  assign enq           = bus.MemWrite & aligned & (~full | deq);
  assign bus.Stall     = bus.MemWrite & aligned & full & ~deq;
  assign bus.empty     = cnt == '0;
  assign bus.mem_valid = ~bus.empty;
  assign bus.mem_addr  = addr_q[rd_ptr];
  assign bus.mem_wdata = data_q[rd_ptr];
  assign bus.count     = cnt;
  assign bus.align_err = err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(enq) - (PW+1)'(deq);
      if (bus.MemWrite && !aligned) err <= 1'b1;
    end
  // storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk)
    if (enq) begin
      addr_q[wr_ptr] <= bus.DataAdr;
      data_q[wr_ptr] <= bus.WriteData;
    end
`ifdef DMEM_WB_FORWARD_EN
  logic [PW-1:0] idx;
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < cnt && addr_q[idx] == bus.LoadAdr) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[idx];
      end
    end
  end
`endif
endmodule
